_piso8_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake
//  and drives it out one bit per shift strobe on a single serial line.

---
 rtl/_piso8_tx_pkg.sv | 10 +
 rtl/_shreg_piso.sv | 30 +++
 rtl/_piso8_tx.sv | 83 ++++++++
 tb/tb__piso8_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/_piso8_tx_pkg.sv
// Shared definitions for the _piso8_tx transmitter: FSM state encoding.
// The encoding is kept bit-identical to the legacy ST_IDLE/ST_SHIFT values.
package _piso_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;

endpackage

// File: rtl/_shreg_piso.sv
// WIDTH-bit parallel-load shift register with sync reset; shifts toward the
// output end (bit 0 when LSB_FIRST, else bit WIDTH-1) with zero fill.
module _shreg_piso #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             out_bit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (LSB_FIRST != 0) q <= {1'b0, q[WIDTH-1:1]};
      else                q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign out_bit = (LSB_FIRST != 0) ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/_piso8_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per
// shift_en strobe, with remaining-bit count and an end-of-frame pulse.
module _piso8_tx
  import _piso_defs::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       shift_en,
  output logic                       sout,
  output logic                       sout_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       frame_done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  piso_state_t   state;
  logic [CW-1:0] cnt;
  logic          do_load;
  logic          do_shift;
  logic          sh_out;

  assign do_load  = (state == ST_IDLE)  && load_valid;
  assign do_shift = (state == ST_SHIFT) && shift_en;

  // Shifting on the final strobe too leaves the register all-zero between frames.
  _shreg_piso #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (do_load),
    .shift   (do_shift),
    .din     (load_data),
    .out_bit (sh_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state <= ST_SHIFT;
            cnt   <= CW'(WIDTH);
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (cnt == CW'(1)) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign load_ready = (state == ST_IDLE);
  assign sout_valid = (state == ST_SHIFT);
  assign sout       = sout_valid & sh_out;
  assign bit_cnt    = cnt;

endmodule

// File: tb/tb__piso8_tx.sv
// Scoreboard bench for _piso8_tx: one LSB-first and one MSB-first instance,
// expected bit streams queued by stimulus and consumed by a negedge monitor.
module tb__piso8_tx;

  logic       clk;
  logic       rst [2];
  logic       lv  [2];
  logic [7:0] ld  [2];
  logic       sen [2];
  logic       lr  [2];
  logic       so  [2];
  logic       sv  [2];
  logic [3:0] bc  [2];
  logic       fd  [2];

  logic [4:0] expq [2][$];
  logic       pend [2];
  logic [4:0] mon_e;
  int         n_pass  = 0;
  int         n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  _piso8_tx #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0]), .shift_en(sen[0]), .sout(so[0]), .sout_valid(sv[0]),
    .bit_cnt(bc[0]), .frame_done(fd[0])
  );

  _piso8_tx #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .shift_en(sen[1]), .sout(so[1]), .sout_valid(sv[1]),
    .bit_cnt(bc[1]), .frame_done(fd[1])
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // seq lists the serial bits in transmission order, first bit in seq[7].
  task automatic push_seq(input int i, input logic [7:0] seq);
    for (int k = 0; k < 8; k++) expq[i].push_back({seq[7-k], 4'(8 - k)});
  endtask

  task automatic wait_done(input int i, input int limit, output int cyc);
    cyc = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (fd[i]) begin
        cyc = c;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        pend[i] = 1'b0;
      end else begin
        check($sformatf("frame_done[%0d]", i), fd[i], pend[i]);
        pend[i] = 1'b0;
        if (sv[i]) begin
          if (expq[i].size() == 0) begin
            check($sformatf("spurious_sout_valid[%0d]", i), sv[i], 1'b0);
          end else begin
            mon_e = expq[i][0];
            check($sformatf("sout[%0d]", i), so[i], mon_e[4]);
            check($sformatf("bit_cnt[%0d]", i), bc[i], mon_e[3:0]);
            if (sen[i]) begin
              void'(expq[i].pop_front());
              if (mon_e[3:0] == 4'd1) pend[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; lv[i] = 1'b0; ld[i] = '0; sen[i] = 1'b0; pend[i] = 1'b0;
    end

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t1_sout[%0d]", i), so[i], 1'b0);
      check($sformatf("t1_sout_valid[%0d]", i), sv[i], 1'b0);
      check($sformatf("t1_bit_cnt[%0d]", i), bc[i], 4'd0);
      check($sformatf("t1_load_ready[%0d]", i), lr[i], 1'b1);
    end

    // 2: LSB-first 8'hA5, shift_en held
    @(posedge clk); #1;
    lv[0] = 1'b1; ld[0] = 8'hA5; sen[0] = 1'b1;
    push_seq(0, 8'b1010_0101);
    @(posedge clk); #1 lv[0] = 1'b0;
    wait_done(0, 40, cyc);
    check("t2_done_cycle", cyc, 9);
    check("t2_ready_at_done", lr[0], 1'b1);
    check("t2_queue_empty", expq[0].size(), 0);

    // 3: MSB-first 8'h81 with 3-cycle stall on the first bit
    @(posedge clk); #1;
    lv[1] = 1'b1; ld[1] = 8'h81; sen[1] = 1'b0;
    push_seq(1, 8'b1000_0001);
    @(posedge clk); #1 lv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 sen[1] = 1'b1;
    wait_done(1, 40, cyc);
    check("t3_done_cycle", cyc, 9);
    check("t3_queue_empty", expq[1].size(), 0);
    @(posedge clk); #1 sen[1] = 1'b0;

    // 4: load attempt while busy is ignored
    lv[0] = 1'b1; ld[0] = 8'h0F; sen[0] = 1'b1;
    push_seq(0, 8'b1111_0000);
    @(posedge clk); #1 lv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 lv[0] = 1'b1; ld[0] = 8'hF0;
    @(negedge clk);
    check("t4_ready_busy", lr[0], 1'b0);
    @(posedge clk); #1 lv[0] = 1'b0;
    wait_done(0, 40, cyc);
    check("t4_done_seen", (cyc != 0), 1'b1);
    repeat (3) @(negedge clk);
    check("t4_no_extra_frame", sv[0], 1'b0);
    check("t4_queue_empty", expq[0].size(), 0);

    // 5: back-to-back 8'h3C then 8'hC3 with load_valid held
    @(posedge clk); #1;
    lv[0] = 1'b1; ld[0] = 8'h3C;
    push_seq(0, 8'b0011_1100);
    push_seq(0, 8'b1100_0011);
    @(posedge clk); #1 ld[0] = 8'hC3;
    wait_done(0, 40, cyc);
    check("t5_first_done_cycle", cyc, 9);
    check("t5_ready_at_done", lr[0], 1'b1);
    @(posedge clk); #1 lv[0] = 1'b0;
    @(negedge clk);
    check("t5_gap_sout_valid", sv[0], 1'b1);
    check("t5_gap_bit_cnt", bc[0], 4'd8);
    wait_done(0, 40, cyc);
    check("t5_second_done_cycle", cyc, 8);
    check("t5_queue_empty", expq[0].size(), 0);

    // 6: reset after 3 bits of 8'hFF, then 8'h01
    @(posedge clk); #1;
    lv[0] = 1'b1; ld[0] = 8'hFF;
    push_seq(0, 8'b1111_1111);
    @(posedge clk); #1 lv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b1; sen[0] = 1'b0;
    expq[0].delete();
    @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    check("t6_sout_valid", sv[0], 1'b0);
    check("t6_bit_cnt", bc[0], 4'd0);
    check("t6_frame_done", fd[0], 1'b0);
    check("t6_load_ready", lr[0], 1'b1);
    @(posedge clk); #1;
    lv[0] = 1'b1; ld[0] = 8'h01; sen[0] = 1'b1;
    push_seq(0, 8'b1000_0000);
    @(posedge clk); #1 lv[0] = 1'b0;
    wait_done(0, 40, cyc);
    check("t6_reload_done_cycle", cyc, 9);
    check("t6_queue_empty", expq[0].size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
